// File: rtl/jam_pkg.sv
// jam_pkg: sizing, permutation count and FSM states shared by the permutation source and the JAM cost stage.
package jam_pkg;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CW = 16;

    function automatic int fact(input int n);
        int f;
        f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    localparam int PERM_TOTAL = fact(N);

    typedef enum logic [2:0] {IDLE, EMIT, FIND_I, FIND_J, SWAP, REVERSE, FIN} state_e;
endpackage

// File: rtl/jam_perm_gen.sv
// jam_perm_gen: emits every permutation of 0..N-1 in lexicographic order over a valid/ready port.
module jam_perm_gen #(
    parameter int N  = jam_pkg::N,
    parameter int IW = jam_pkg::IW,
    parameter int CW = jam_pkg::CW
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    output logic [N*IW-1:0] perm_out,
    output logic            perm_valid,
    input  logic            perm_ready,
    output logic [CW-1:0]   perm_index,
    output logic            last,
    output logic            busy,
    output logic            done
);
    import jam_pkg::*;

    localparam int          TOTAL = fact(N);
    localparam logic [IW:0] TOP   = (IW+1)'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] num_q [N];
    logic [IW-1:0] num_d [N];
    logic [IW:0]   i_q, i_d, j_q, j_d, lo_q, lo_d, hi_q, hi_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic [IW-1:0] ia, ib, ja, la, ha;

    // Cursors carry an extra bit so hi-- at zero cannot wrap; only the low bits address the element file.
    assign ia = i_q[IW-1:0];
    assign ib = IW'(i_q + 1'b1);
    assign ja = j_q[IW-1:0];
    assign la = lo_q[IW-1:0];
    assign ha = hi_q[IW-1:0];

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        i_d     = i_q;
        j_d     = j_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = EMIT;
                idx_d   = '0;
                for (int k = 0; k < N; k++) num_d[k] = IW'(k);
            end
            EMIT: if (perm_ready) begin
                state_d = last_q ? FIN : FIND_I;
                i_d     = TOP - 1'b1;
            end
            FIND_I: if (num_q[ia] < num_q[ib]) begin
                state_d = FIND_J;
                j_d     = TOP;
            end else begin
                i_d = i_q - 1'b1;
            end
            FIND_J: if (num_q[ja] > num_q[ia]) state_d = SWAP;
                    else j_d = j_q - 1'b1;
            SWAP: begin
                num_d[ia] = num_q[ja];
                num_d[ja] = num_q[ia];
                lo_d      = i_q + 1'b1;
                hi_d      = TOP;
                state_d   = REVERSE;
            end
            REVERSE: if (lo_q < hi_q) begin
                num_d[la] = num_q[ha];
                num_d[ha] = num_q[la];
                lo_d      = lo_q + 1'b1;
                hi_d      = hi_q - 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = EMIT;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = state_d == EMIT;
        last_d  = state_d == EMIT && idx_d == CW'(TOTAL - 1);
        busy_d  = state_d != IDLE;
        done_d  = state_d == FIN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            for (int k = 0; k < N; k++) num_q[k] <= IW'(k);
            i_q     <= '0;
            j_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            i_q     <= i_d;
            j_q     <= j_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign perm_out[IW*k +: IW] = num_q[k];
    end

    assign perm_valid = valid_q;
    assign perm_index = idx_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
